// File: rtl/wb_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response pulse out.
// Optional bus-cycle watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master #(
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // command side
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [DW-1:0] cmd_dat_i,
  // response side
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  // wishbone bus
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          we_reg, we_next;
  logic [AW-1:0] adr_reg, adr_next;
  logic [DW-1:0] dat_reg, dat_next;
  logic [DW-1:0] rsp_dat_reg, rsp_dat_next;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_reg, cnt_next;
  logic        rsp_err_reg, rsp_err_next;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Bus address/data and response registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      rsp_dat_reg <= '0;
    end else begin
      we_reg      <= we_next;
      adr_reg     <= adr_next;
      dat_reg     <= dat_next;
      rsp_dat_reg <= rsp_dat_next;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg     <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      rsp_err_reg <= rsp_err_next;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    we_next      = we_reg;
    adr_next     = adr_reg;
    dat_next     = dat_reg;
    rsp_dat_next = rsp_dat_reg;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_next     = cnt_reg;
    rsp_err_next = rsp_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          state_next = BUS;
          we_next    = cmd_we_i;
          adr_next   = cmd_adr_i;
          dat_next   = cmd_dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end

      BUS: begin
        // An ack on the expiry edge takes priority over the timeout.
        if (ack_i) begin
          state_next   = DONE;
          rsp_dat_next = we_reg ? '0 : dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_next = 1'b0;
`endif
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (cnt_reg == TIMEOUT_LAST) begin
          state_next   = DONE;
          rsp_dat_next = '0;
          rsp_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
`endif
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus strobes decode straight from the state so reset drops them at once.
  assign cmd_ready_o = (state_reg == IDLE);
  assign cyc_o       = (state_reg == BUS);
  assign stb_o       = (state_reg == BUS);
  assign rsp_valid_o = (state_reg == DONE);
  assign we_o        = we_reg;
  assign adr_o       = adr_reg;
  assign dat_o       = dat_reg;
  assign rsp_dat_o   = rsp_dat_reg;

`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_reg;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
